// File: rtl/banked_multiport_ram_if.sv
// ---------------------------------------------------------------------------
// banked_multiport_ram_if
//   Core-side bus bundle for banked_multiport_ram. Every signal is a packed
//   per-port array, so port p sits at [p] (the same bit layout as a flat
//   vector sliced at [p*width +: width]).
//
//   req        core -> ram  per-port access request
//   mem_write  core -> ram  1 = write, 0 = read (qualified by req)
//   address    core -> ram  word address per port
//   datain     core -> ram  write data per port
//   grant      ram -> core  access accepted this cycle (combinational)
//   rvalid     ram -> core  dataout valid this cycle
//   dataout    ram -> core  registered read data per port
//
//   master: the cores' view.  slave: the RAM's view.
// ---------------------------------------------------------------------------
interface banked_multiport_ram_if #(
  parameter int port_count = 2,
  parameter int addr_width = 12,
  parameter int mem_width  = 12
) ();

  logic [port_count-1:0]                 req;
  logic [port_count-1:0]                 mem_write;
  logic [port_count-1:0][addr_width-1:0] address;
  logic [port_count-1:0][mem_width-1:0]  datain;
  logic [port_count-1:0]                 grant;
  logic [port_count-1:0]                 rvalid;
  logic [port_count-1:0][mem_width-1:0]  dataout;

  modport master (
    output req, mem_write, address, datain,
    input  grant, rvalid, dataout
  );

  modport slave (
    input  req, mem_write, address, datain,
    output grant, rvalid, dataout
  );

endinterface

// File: rtl/banked_multiport_ram.sv
// ---------------------------------------------------------------------------
// banked_multiport_ram
//   Shared data memory for the multi-core system. The word space is split
//   into 2**bank_bits low-order-interleaved banks; each bank serves one
//   access per cycle, chosen by its own round-robin arbiter. Losing cores
//   see grant=0 and must hold their request until granted. Reads return
//   one cycle after the grant with an rvalid strobe. conflict_count counts
//   (saturating) the cycles in which at least one request was stalled.
//
//   clk             system clock
//   reset           synchronous, active-high reset
//   bus             banked_multiport_ram_if.slave (req/mem_write/address/
//                   datain in; grant/rvalid/dataout out)
//   conflict_count  saturating count of cycles with a stalled request
// ---------------------------------------------------------------------------
module banked_multiport_ram #(
  parameter int mem_width  = 12,
  parameter int addr_width = 12,
  parameter int port_count = 2,
  parameter int bank_bits  = 1,
  parameter int cnt_width  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  banked_multiport_ram_if.slave      bus,
  output logic [cnt_width-1:0]       conflict_count
);

  localparam int bank_count = 1 << bank_bits;
  localparam int row_width  = addr_width - bank_bits;
  localparam int bank_idx_w = (bank_bits > 0) ? bank_bits : 1;
  localparam int ptr_w      = (port_count > 1) ? $clog2(port_count) : 1;

  // -------------------------------------------------------------------------
  // Address decode: low bits pick the bank, the rest pick the row in it.
  // -------------------------------------------------------------------------
  logic [port_count-1:0][bank_idx_w-1:0] port_bank;
  logic [port_count-1:0][row_width-1:0]  port_row;

  always_comb begin
    port_bank = '0;
    port_row  = '0;
    for (int p = 0; p < port_count; p++) begin
      port_bank[p] = (bank_bits == 0) ? '0 : bus.address[p][bank_idx_w-1:0];
      port_row[p]  = row_width'(bus.address[p] >> bank_bits);
    end
  end

  // -------------------------------------------------------------------------
  // Per-bank round-robin arbitration. Each bank scans ports starting at its
  // rr_ptr and wrapping; the first requester aimed at the bank wins. A port
  // only ever targets one bank, so grants from different banks never clash.
  // Reset suppresses every grant, which also blocks writes and reads.
  // -------------------------------------------------------------------------
  logic [bank_count-1:0][ptr_w-1:0] rr_ptr;
  logic [bank_count-1:0][ptr_w-1:0] bank_win;
  logic [bank_count-1:0]            bank_hit;
  logic [port_count-1:0]            grant_c;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    int               idx;
    logic [ptr_w-1:0] pidx;
    idx      = 0;
    pidx     = '0;
    grant_c  = '0;
    bank_hit = '0;
    bank_win = '0;
    if (!reset) begin
      for (int b = 0; b < bank_count; b++) begin
        for (int k = 0; k < port_count; k++) begin
          idx = int'(rr_ptr[b]) + k;
          if (idx >= port_count) idx = idx - port_count;
          pidx = ptr_w'(idx);
          if (!bank_hit[b] && bus.req[pidx] &&
              port_bank[pidx] == bank_idx_w'(b)) begin
            bank_hit[b]   = 1'b1;
            bank_win[b]   = pidx;
            grant_c[pidx] = 1'b1;
          end
        end
      end
    end
  end

  assign bus.grant = grant_c;

  // -------------------------------------------------------------------------
  // Per-bank access mux: route the winning port's row/data/direction to the
  // bank. Only one access per bank, so each bank is a simple 1RW array.
  // -------------------------------------------------------------------------
  logic [bank_count-1:0]                bank_we;
  logic [bank_count-1:0]                bank_re;
  logic [bank_count-1:0][row_width-1:0] bank_row;
  logic [bank_count-1:0][mem_width-1:0] bank_wdata;

  always_comb begin
    bank_we    = '0;
    bank_re    = '0;
    bank_row   = '0;
    bank_wdata = '0;
    for (int b = 0; b < bank_count; b++) begin
      bank_row[b]   = port_row[bank_win[b]];
      bank_wdata[b] = bus.datain[bank_win[b]];
      bank_we[b]    = bank_hit[b] &  bus.mem_write[bank_win[b]];
      bank_re[b]    = bank_hit[b] & ~bus.mem_write[bank_win[b]];
    end
  end

  logic [mem_width-1:0] bank_rdata [bank_count];

  for (genvar b = 0; b < bank_count; b++) begin : g_bank
    logic [mem_width-1:0] mem [2**row_width];
    logic [mem_width-1:0] rdata_q;

    // NOTE: the storage array and its read register have no reset branch;
    // clearing a RAM is not possible in one cycle and would stop it mapping
    // onto a memory macro. Stale read data is hidden behind rvalid/dataout.
    always_ff @(posedge clk) begin
      if (bank_we[b]) mem[bank_row[b]] <= bank_wdata[b];
      if (bank_re[b]) rdata_q <= mem[bank_row[b]];
    end

    assign bank_rdata[b] = rdata_q;
  end

  // -------------------------------------------------------------------------
  // Per-port read return. rd_bank_q remembers which bank serves the port's
  // read; hold_q keeps the last delivered word for cycles without rvalid.
  // -------------------------------------------------------------------------
  logic [port_count-1:0]                 rvalid_q;
  logic [port_count-1:0][bank_idx_w-1:0] rd_bank_q;
  logic [port_count-1:0][mem_width-1:0]  hold_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q  <= '0;
      rd_bank_q <= '0;
      hold_q    <= '0;
    end else begin
      for (int p = 0; p < port_count; p++) begin
        rvalid_q[p]  <= grant_c[p] & ~bus.mem_write[p];
        rd_bank_q[p] <= port_bank[p];
        if (rvalid_q[p]) hold_q[p] <= bank_rdata[rd_bank_q[p]];
      end
    end
  end

  // A read granted just before reset rises is already in flight; masking
  // the outputs while reset is high keeps it from ever being presented.
  assign bus.rvalid = reset ? '0 : rvalid_q;

  always_comb begin
    bus.dataout = '0;
    for (int p = 0; p < port_count; p++) begin
      if (!reset) begin
        bus.dataout[p] = rvalid_q[p] ? bank_rdata[rd_bank_q[p]] : hold_q[p];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pointers and the saturating conflict counter.
  // -------------------------------------------------------------------------
  logic stall;
  assign stall = |(bus.req & ~grant_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= '0;
      conflict_count <= '0;
    end else begin
      for (int b = 0; b < bank_count; b++) begin
        if (bank_hit[b]) begin
          rr_ptr[b] <= (bank_win[b] == ptr_w'(port_count - 1)) ? '0
                                                                : bank_win[b] + 1'b1;
        end
      end
      if (stall && (conflict_count != '1)) begin
        conflict_count <= conflict_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_banked_multiport_ram.sv
// ---------------------------------------------------------------------------
// tb_banked_multiport_ram
//   Directed bench for two instances: dut_a (2 ports, 2 banks, 16-bit
//   counter) and dut_b (3 ports, single bank, 4-bit counter). Expected read
//   words come from a reference memory and are queued when the read is
//   issued, then popped and compared when rvalid is due.
// ---------------------------------------------------------------------------
module tb_banked_multiport_ram;

  logic clk;
  logic reset;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  banked_multiport_ram_if #(.port_count(2), .addr_width(12), .mem_width(12)) ifa ();
  banked_multiport_ram_if #(.port_count(3), .addr_width(12), .mem_width(12)) ifb ();

  banked_multiport_ram #(
    .mem_width(12), .addr_width(12), .port_count(2), .bank_bits(1), .cnt_width(16)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .conflict_count(cnt_a)
  );

  banked_multiport_ram #(
    .mem_width(12), .addr_width(12), .port_count(3), .bank_bits(0), .cnt_width(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .conflict_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    int          port;
    logic [11:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  logic [11:0] ref_a [4096];
  logic [11:0] ref_b [4096];
  int          total;
  int          bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int dut, input int port, input logic [11:0] data);
    rd_exp_t e;
    e.dut  = dut;
    e.port = port;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_a(input int p, input logic rq, input logic we,
                       input logic [11:0] ad, input logic [11:0] d);
    ifa.req[p]       = rq;
    ifa.mem_write[p] = we;
    ifa.address[p]   = ad;
    ifa.datain[p]    = d;
  endtask

  task automatic set_b(input int p, input logic rq, input logic we,
                       input logic [11:0] ad, input logic [11:0] d);
    ifb.req[p]       = rq;
    ifb.mem_write[p] = we;
    ifb.address[p]   = ad;
    ifb.datain[p]    = d;
  endtask

  // Pop every queued read: each must show rvalid and its word now; every
  // other port must show rvalid low.
  task automatic check_reads(input string tag);
    logic [1:0]  erv_a;
    logic [2:0]  erv_b;
    logic [11:0] eda [2];
    logic [11:0] edb [3];
    rd_exp_t     e;
    erv_a = '0;
    erv_b = '0;
    for (int p = 0; p < 2; p++) eda[p] = '0;
    for (int p = 0; p < 3; p++) edb[p] = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int p = 0; p < 3; p++) begin
        if (e.port == p && e.dut == 0 && p < 2) begin
          erv_a[p] = 1'b1;
          eda[p]   = e.data;
        end
        if (e.port == p && e.dut == 1) begin
          erv_b[p] = 1'b1;
          edb[p]   = e.data;
        end
      end
    end
    check({tag, ".rvalid_a"}, 32'(ifa.rvalid), 32'(erv_a));
    check({tag, ".rvalid_b"}, 32'(ifb.rvalid), 32'(erv_b));
    for (int p = 0; p < 2; p++)
      if (erv_a[p]) check($sformatf("%s.dout_a%0d", tag, p), 32'(ifa.dataout[p]), 32'(eda[p]));
    for (int p = 0; p < 3; p++)
      if (erv_b[p]) check($sformatf("%s.dout_b%0d", tag, p), 32'(ifb.dataout[p]), 32'(edb[p]));
  endtask

  // One clock: grants checked at the falling edge, registered outputs 1ns
  // after the rising edge. Inputs are set by the caller beforehand.
  task automatic run_cycle(input logic [1:0] ega, input logic [2:0] egb, input string tag);
    @(negedge clk);
    check({tag, ".grant_a"}, 32'(ifa.grant), 32'(ega));
    check({tag, ".grant_b"}, 32'(ifb.grant), 32'(egb));
    @(posedge clk);
    #1;
    check_reads(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ega;
    logic [2:0] egb;
    int         exp_cnt;
    total = 0;
    bad   = 0;

    // ---- reset with every port requesting --------------------------------
    reset = 1'b1;
    set_a(0, 1'b1, 1'b0, 12'h004, 12'h000);
    set_a(1, 1'b1, 1'b0, 12'h010, 12'h000);
    for (int p = 0; p < 3; p++) set_b(p, 1'b1, 1'b0, 12'(p), 12'h000);
    run_cycle(2'b00, 3'b000, "rst1");
    run_cycle(2'b00, 3'b000, "rst2");
    check("rst.dout_a0", 32'(ifa.dataout[0]), 32'h0);
    check("rst.dout_a1", 32'(ifa.dataout[1]), 32'h0);
    check("rst.cnt_a", 32'(cnt_a), 32'h0);
    check("rst.cnt_b", 32'(cnt_b), 32'h0);

    reset = 1'b0;
    set_a(0, 1'b0, 1'b0, 12'h000, 12'h000);
    set_a(1, 1'b0, 1'b0, 12'h000, 12'h000);
    for (int p = 0; p < 3; p++) set_b(p, 1'b0, 1'b0, 12'h000, 12'h000);
    run_cycle(2'b00, 3'b000, "idle");
    check("idle.dout_a0", 32'(ifa.dataout[0]), 32'h0);
    check("idle.dout_a1", 32'(ifa.dataout[1]), 32'h0);
    check("idle.cnt_a", 32'(cnt_a), 32'h0);

    // ---- write then read back --------------------------------------------
    set_a(0, 1'b1, 1'b1, 12'h004, 12'hABC);
    ref_a[12'h004] = 12'hABC;
    run_cycle(2'b01, 3'b000, "t2.wr");
    set_a(0, 1'b1, 1'b0, 12'h004, 12'h000);
    push(0, 0, ref_a[12'h004]);
    run_cycle(2'b01, 3'b000, "t2.rd");

    // ---- preload: parallel writes on both banks, then p1 alone on bank 0 --
    set_a(0, 1'b1, 1'b1, 12'h010, 12'h111);
    set_a(1, 1'b1, 1'b1, 12'h011, 12'h222);
    ref_a[12'h010] = 12'h111;
    ref_a[12'h011] = 12'h222;
    run_cycle(2'b11, 3'b000, "pre1");
    set_a(0, 1'b0, 1'b0, 12'h000, 12'h000);
    set_a(1, 1'b1, 1'b1, 12'h020, 12'h333);
    ref_a[12'h020] = 12'h333;
    run_cycle(2'b10, 3'b000, "pre2");
    check("pre.cnt_a", 32'(cnt_a), 32'h0);

    // ---- same-bank conflict: grants alternate p0,p1,p0,p1 ----------------
    set_a(0, 1'b1, 1'b0, 12'h010, 12'h000);
    set_a(1, 1'b1, 1'b0, 12'h020, 12'h000);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        ega = 2'b01;
        push(0, 0, ref_a[12'h010]);
      end else begin
        ega = 2'b10;
        push(0, 1, ref_a[12'h020]);
      end
      run_cycle(ega, 3'b000, $sformatf("t3.c%0d", i));
    end
    check("t3.cnt_a", 32'(cnt_a), 32'd4);

    // ---- different banks: both granted every cycle ------------------------
    set_a(0, 1'b1, 1'b0, 12'h010, 12'h000);
    set_a(1, 1'b1, 1'b0, 12'h011, 12'h000);
    for (int i = 0; i < 3; i++) begin
      push(0, 0, ref_a[12'h010]);
      push(0, 1, ref_a[12'h011]);
      run_cycle(2'b11, 3'b000, $sformatf("t4.c%0d", i));
    end
    check("t4.cnt_a", 32'(cnt_a), 32'd4);

    // ---- reads granted, then reset rises before their data appears -------
    // p0 on bank 1 leaves rr_ptr[1]=1; reset must bring it back to 0.
    set_a(0, 1'b1, 1'b0, 12'h011, 12'h000);
    set_a(1, 1'b1, 1'b0, 12'h020, 12'h000);
    @(negedge clk);
    check("t5.grant_a", 32'(ifa.grant), 32'h3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_a(0, 1'b1, 1'b1, 12'h004, 12'h7FF);  // must be dropped
    #1;
    check("t5.rvalid_a", 32'(ifa.rvalid), 32'h0);
    check("t5.dout_a1", 32'(ifa.dataout[1]), 32'h0);
    run_cycle(2'b00, 3'b000, "t5.rst1");
    run_cycle(2'b00, 3'b000, "t5.rst2");

    reset = 1'b0;
    set_a(0, 1'b1, 1'b0, 12'h011, 12'h000);
    set_a(1, 1'b1, 1'b0, 12'h011, 12'h000);
    push(0, 0, ref_a[12'h011]);
    run_cycle(2'b01, 3'b000, "t5.r1");
    check("t5.hold_a1", 32'(ifa.dataout[1]), 32'h0);
    check("t5.r1.cnt_a", 32'(cnt_a), 32'd1);
    set_a(0, 1'b1, 1'b0, 12'h004, 12'h000);
    push(0, 0, ref_a[12'h004]);
    push(0, 1, ref_a[12'h011]);
    run_cycle(2'b11, 3'b000, "t5.r2");
    check("t5.r2.cnt_a", 32'(cnt_a), 32'd1);
    set_a(0, 1'b0, 1'b0, 12'h000, 12'h000);
    set_a(1, 1'b0, 1'b0, 12'h000, 12'h000);

    // ---- 3 ports, one bank, everyone requesting for 20 cycles ------------
    for (int p = 0; p < 3; p++) begin
      set_b(p, 1'b1, 1'b1, 12'(p + 1), 12'(12'h100 + p));
      ref_b[p + 1] = 12'(12'h100 + p);
    end
    for (int i = 0; i < 20; i++) begin
      egb     = 3'(1 << (i % 3));
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      run_cycle(2'b00, egb, $sformatf("t6.c%0d", i));
      check($sformatf("t6.c%0d.cnt_b", i), 32'(cnt_b), 32'(exp_cnt));
    end
    set_b(0, 1'b1, 1'b0, 12'h003, 12'h000);
    set_b(1, 1'b0, 1'b0, 12'h000, 12'h000);
    set_b(2, 1'b0, 1'b0, 12'h000, 12'h000);
    push(1, 0, ref_b[3]);
    run_cycle(2'b00, 3'b001, "t6.rd");
    check("t6.cnt_b_sat", 32'(cnt_b), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
